fir_dec_mac_sched: RTL

//  Time-multiplexed scheduler for a decimating FIR filter using a single multiply-accumulate (MAC) unit.
//  - Accepts input samples over a valid/ready handshake and stores them in an NTAPS-deep circular delay line.
//  - Every DEC-th accepted sample, steps one MAC through all NTAPS taps, reading coefficients from an external ROM.
//  - Presents the decimated result on a valid/ready output.
//  - Replaces the fully parallel transposed-form filter when throughput allows a 1/DEC output rate.

---
 rtl/fir_dec_mac_sched.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fir_dec_mac_sched.sv
// Decimating FIR scheduler: one MAC steps all taps every DEC-th accepted sample.
// Define FIR_DEC_SAT_EN to saturate the output instead of wrapping it.
module fir_dec_mac_sched #(
    parameter int WIN   = 8,
    parameter int WCOEF = 10,
    parameter int WOUT  = 20,
    parameter int NTAPS = 21,
    parameter int DEC   = 5,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIN-1:0]   x_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [AW-1:0]    coef_addr,
    input  logic [WCOEF-1:0] coef_data,
    output logic [WOUT-1:0]  y_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int ACCW = WIN + WCOEF + AW;
    localparam int WW   = WIN + WCOEF;
    localparam int EW   = ACCW + WOUT;
    localparam int PW   = (DEC > 1) ? $clog2(DEC) : 1;

`ifdef FIR_DEC_SAT_EN
    localparam logic signed [EW-1:0] ONE  = EW'(1);
    localparam logic signed [EW-1:0] SMAX = (ONE <<< (WOUT - 1)) - ONE;
    localparam logic signed [EW-1:0] SMIN = -SMAX - ONE;
`endif

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                  state;
    logic [PW-1:0]           phase;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           base;
    logic [AW-1:0]           k;
    logic signed [WIN-1:0]   dly [NTAPS];
    logic signed [ACCW-1:0]  acc;

    logic [AW-1:0]           rd_idx;
    logic signed [WW-1:0]    prod;
    logic signed [ACCW-1:0]  sum;
    logic [WOUT-1:0]         y_next;

    // Wide sign extension makes both wrap and clamp exact for any ACCW/WOUT mix
    function automatic logic [WOUT-1:0] form(input logic signed [ACCW-1:0] a);
        logic signed [EW-1:0] w;
        w = EW'(a);
`ifdef FIR_DEC_SAT_EN
        if (w > SMAX)
            w = SMAX;
        else if (w < SMIN)
            w = SMIN;
`endif
        return WOUT'(w);
    endfunction

    // Modulo-2^AW arithmetic is exact because the true index is below NTAPS
    always_comb begin
        rd_idx = base - k;
        if (k > base)
            rd_idx = base - k + AW'(NTAPS);
        prod   = WW'($signed(coef_data)) * WW'(dly[rd_idx]);
        sum    = acc + {{AW{prod[WW-1]}}, prod};
        y_next = form(sum);
    end

    assign coef_addr = k;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            phase     <= '0;
            wr_ptr    <= '0;
            base      <= '0;
            k         <= '0;
            acc       <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < NTAPS; i++)
                dly[i] <= '0;
        end else if (flush) begin
            state     <= IDLE;
            phase     <= '0;
            wr_ptr    <= '0;
            base      <= '0;
            k         <= '0;
            acc       <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            for (int i = 0; i < NTAPS; i++)
                dly[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        dly[wr_ptr] <= $signed(x_in);
                        wr_ptr <= (wr_ptr == AW'(NTAPS - 1)) ? '0 : wr_ptr + 1'b1;
                        if (phase == PW'(DEC - 1)) begin
                            phase    <= '0;
                            base     <= wr_ptr;
                            acc      <= '0;
                            k        <= '0;
                            state    <= MAC;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end
                MAC: begin
                    acc <= sum;
                    if (k == AW'(NTAPS - 1)) begin
                        y_out     <= y_next;
                        out_valid <= 1'b1;
                        k         <= '0;
                        state     <= OUT;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
